// File: rtl/div_iter_pkg.sv
// ============================================================================
// div_iter_pkg : shared state encoding and sizing helper for div_iter. rev 1.0
// ============================================================================
`default_nettype none

package div_iter_pkg;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'b00,
        DIV_ST_BUSY = 2'b01,
        DIV_ST_DONE = 2'b10
    } div_state_e;

    function automatic int div_cnt_len(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_iter_step.sv
// ============================================================================
// div_iter_step : one combinational restoring-division iteration. rev 1.0
// ============================================================================
`default_nettype none

module div_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             a_bit,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    // One extra bit keeps the compare exact when the divisor exceeds 2^(WIDTH-1).
    logic [WIDTH:0] w_shift;

    assign w_shift = {rem_in, a_bit};
    assign q_bit   = (w_shift >= {1'b0, b});
    assign rem_out = q_bit ? (w_shift[WIDTH-1:0] - b) : w_shift[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/div_iter.sv
// ============================================================================
// div_iter : iterative radix-2 restoring divider, {quotient, remainder} out.
//            DIV_ITER_EARLY_OUT_EN skips iteration for /0 and |a|<|b|. rev 1.0
// ============================================================================
`default_nettype none

module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SIGNED = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
    input  logic                 s_axis_divisor_tvalid,
    output logic                 s_axis_divisor_tready,
    input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
    input  logic                 s_axis_dividend_tvalid,
    output logic                 s_axis_dividend_tready,
    output logic [2*WIDTH-1:0]   m_axis_dout_tdata,
    output logic                 m_axis_dout_tvalid
);

    localparam int                 CNT_LEN    = div_cnt_len(WIDTH);
    localparam logic [CNT_LEN-1:0] C_LAST_CNT = CNT_LEN'(WIDTH - 1);

    div_state_e           state_q, state_d;
    logic [CNT_LEN-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d;         // dividend magnitude, becomes quotient
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic                 negq_q, negq_d;
    logic                 negr_q, negr_d;
    logic                 dz_q, dz_d;
    logic [2*WIDTH-1:0]   dout_q, dout_d;

    logic                 w_accept;
    logic                 w_a_neg, w_b_neg;
    logic [WIDTH-1:0]     w_a_abs, w_b_abs;
    logic                 w_div_zero;
    logic [WIDTH-1:0]     w_rem_step;
    logic                 w_q_bit;
    logic [WIDTH-1:0]     w_quo_fin;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    assign w_accept   = (state_q == DIV_ST_IDLE) && s_axis_divisor_tvalid && s_axis_dividend_tvalid;
    assign w_a_neg    = (SIGNED != 0) && s_axis_dividend_tdata[WIDTH-1];
    assign w_b_neg    = (SIGNED != 0) && s_axis_divisor_tdata[WIDTH-1];
    assign w_a_abs    = w_a_neg ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
    assign w_b_abs    = w_b_neg ? -s_axis_divisor_tdata  : s_axis_divisor_tdata;
    assign w_div_zero = (s_axis_divisor_tdata == '0);

    div_iter_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .a_bit   (a_q[WIDTH-1]),
        .b       (b_q),
        .rem_out (w_rem_step),
        .q_bit   (w_q_bit)
    );

    // With a zero divisor the remainder path reproduces the dividend after sign fix.
    assign w_quo_fin = {a_q[WIDTH-2:0], w_q_bit};
    assign w_quo_fix = dz_q ? {WIDTH{1'b1}} : (negq_q ? -w_quo_fin : w_quo_fin);
    assign w_rem_fix = negr_q ? -w_rem_step : w_rem_step;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        dout_d  = dout_q;

        case (state_q)
            DIV_ST_IDLE: begin
                if (w_accept) begin
                    a_d     = w_a_abs;
                    b_d     = w_b_abs;
                    rem_d   = '0;
                    negq_d  = w_a_neg ^ w_b_neg;
                    negr_d  = w_a_neg;
                    dz_d    = w_div_zero;
                    cnt_d   = '0;
                    state_d = DIV_ST_BUSY;
`ifdef DIV_ITER_EARLY_OUT_EN
                    if (w_div_zero || (w_a_abs < w_b_abs)) begin
                        state_d = DIV_ST_DONE;
                        dout_d  = {{WIDTH{w_div_zero}}, s_axis_dividend_tdata};
                    end
`endif
                end
            end
            DIV_ST_BUSY: begin
                a_d   = w_quo_fin;
                rem_d = w_rem_step;
                cnt_d = cnt_q + CNT_LEN'(1);
                if (cnt_q == C_LAST_CNT) begin
                    state_d = DIV_ST_DONE;
                    dout_d  = {w_quo_fix, w_rem_fix};
                end
            end
            DIV_ST_DONE: begin
                state_d = DIV_ST_IDLE;
            end
            default: begin
                state_d = DIV_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= DIV_ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            dout_q  <= dout_d;
        end
    end

    assign s_axis_divisor_tready  = resetn && (state_q == DIV_ST_IDLE);
    assign s_axis_dividend_tready = resetn && (state_q == DIV_ST_IDLE);
    assign m_axis_dout_tvalid     = (state_q == DIV_ST_DONE);
    assign m_axis_dout_tdata      = dout_q;

endmodule

`default_nettype wire
